// File: rtl/card_mem_pkg.sv
// -----------------------------------------------------------------------------
// card_mem_pkg
//
// Purpose : Shared definitions for every module that operates on the 1024x32
//           card RAM (allocator, list walkers, free_card_list, ...).
//           Holds the default RAM geometry, the card word field layout, a
//           card-word typedef, and the state encoding of the free-list walker.
//
// Card word layout:
//   [31]    USED    - set by the allocator, cleared when the node is freed
//   [30:16] unused
//   [15:12] value
//   [11:10] suit
//   [9:0]   next    - pointer to the next node, 0 terminates the list
//
// Address 0 is never handed out by the allocator, so it doubles as the
// null pointer.
// -----------------------------------------------------------------------------
package card_mem_pkg;

    // Default RAM geometry.
    localparam int CARD_ADDR_W = 10;
    localparam int CARD_DATA_W = 32;

    // Allocation flag and null pointer.
    localparam int                     USED_BIT  = 31;
    localparam logic [CARD_ADDR_W-1:0] NULL_ADDR = '0;

    // Field ranges.
    localparam int VALUE_MSB = 15;
    localparam int VALUE_LSB = 12;
    localparam int SUIT_MSB  = 11;
    localparam int SUIT_LSB  = 10;
    localparam int NEXT_MSB  = 9;
    localparam int NEXT_LSB  = 0;

    // One card word, field by field.
    typedef struct packed {
        logic        used;
        logic [14:0] rsvd;
        logic [3:0]  value;
        logic [1:0]  suit;
        logic [9:0]  next;
    } card_word_t;

    // Free-list walker states.
    typedef enum logic [1:0] {
        FCL_IDLE = 2'd0,
        FCL_RD   = 2'd1,
        FCL_WR   = 2'd2,
        FCL_DONE = 2'd3
    } fcl_state_e;

    // Release a card word while keeping its payload intact.
    function automatic card_word_t card_release(input card_word_t w);
        card_word_t r;
        r      = w;
        r.used = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/free_card_list.sv
// -----------------------------------------------------------------------------
// free_card_list
//
// Purpose : Returns a linked list of card blocks to the free pool. Starting at
//           head_addr it walks the next pointers, clearing the USED bit of
//           every node, counts the nodes freed and flags a node found already
//           free (double free, or a cyclic list revisiting a cleared node).
//
// Configuration macro:
//   FREE_CARD_LIST_SCRUB_EN  defined   -> a freed word is written as all zeros
//                            undefined -> a freed word keeps every field except
//                                         USED ({1'b0, ram_q[30:0]})
//
// Ports:
//   clock        in   single clock
//   resetn       in   asynchronous active-low reset
//   start        in   request to free the list at head_addr (sampled in IDLE)
//   head_addr    in   first node of the list, 0 = empty list
//   busy         out  high from the cycle after acceptance through done
//   done         out  one-cycle completion pulse
//   error        out  a node was already free; held until the next start
//   freed_count  out  nodes freed by the last operation; held until next start
//   ram_address  out  RAM address (combinational from state and cur)
//   ram_data     out  RAM write data
//   ram_wren     out  RAM write enable
//   ram_q        in   RAM read data, valid the cycle after its address
//   dbg_state    out  current walker state (fcl_state_e encoding)
//
// Handshake: start/busy is a request/acknowledge pair. start is accepted on
// any rising edge where the walker is in IDLE (busy low and done low); the
// acceptance edge latches head_addr. While busy is high start is ignored.
// Completion is signalled by the single-cycle done pulse, after which
// error/freed_count stay stable until the next accepted start.
// -----------------------------------------------------------------------------
module free_card_list
    import card_mem_pkg::*;
#(
    parameter int ADDR_W = CARD_ADDR_W,
    parameter int DATA_W = CARD_DATA_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] head_addr,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] freed_count,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q,
    output logic [1:0]        dbg_state
);

    // USED is always the top bit of the word; next is the low ADDR_W bits.
    localparam int W_USED = DATA_W - 1;

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    fcl_state_e        r_state;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_freed_count;
    logic              r_error;

    // -------------------------------------------------------------------------
    // Wires
    // -------------------------------------------------------------------------
    fcl_state_e        w_next_state;
    logic              w_used;
    logic [ADDR_W-1:0] w_next_ptr;
    logic              w_last_node;
    logic              w_head_null;
    logic [DATA_W-1:0] w_freed_word;
    logic              w_accept;
    logic              w_free_node;

    // Node decode: only meaningful in WR, where ram_q holds the node at r_cur.
    assign w_used      = ram_q[W_USED];
    assign w_next_ptr  = ram_q[ADDR_W-1:0];
    assign w_last_node = (w_next_ptr == ADDR_W'(NULL_ADDR));
    assign w_head_null = (head_addr == ADDR_W'(NULL_ADDR));

    assign w_accept    = (r_state == FCL_IDLE) && start;
    assign w_free_node = (r_state == FCL_WR) && w_used;

`ifdef FREE_CARD_LIST_SCRUB_EN
    // Scrub mode erases the whole word, so the payload bits of ram_q are
    // never consumed here.
    logic w_unused_q;
    assign w_unused_q   = ^ram_q;
    assign w_freed_word = '0;
`else
    assign w_freed_word = {1'b0, ram_q[W_USED-1:0]};
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= FCL_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next state and RAM port decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        ram_address  = '0;
        ram_data     = '0;
        ram_wren     = 1'b0;

        case (r_state)
            FCL_IDLE: begin
                if (start) begin
                    // An empty list completes without touching the RAM.
                    w_next_state = w_head_null ? FCL_DONE : FCL_RD;
                end
            end

            FCL_RD: begin
                // Present the node address; the RAM registers it, so the
                // word appears on ram_q during the following WR cycle.
                busy         = 1'b1;
                ram_address  = r_cur;
                w_next_state = FCL_WR;
            end

            FCL_WR: begin
                busy        = 1'b1;
                ram_address = r_cur;
                if (w_used) begin
                    ram_wren     = 1'b1;
                    ram_data     = w_freed_word;
                    w_next_state = w_last_node ? FCL_DONE : FCL_RD;
                end else begin
                    // Already free: either a double free or the walk has come
                    // back round to a node it cleared earlier in this list.
                    w_next_state = FCL_DONE;
                end
            end

            FCL_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_next_state = FCL_IDLE;
            end

            default: begin
                w_next_state = FCL_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: current node pointer, freed counter, error flag
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_cur         <= '0;
            r_freed_count <= '0;
            r_error       <= 1'b0;
        end else if (w_accept) begin
            r_cur         <= head_addr;
            r_freed_count <= '0;
            r_error       <= 1'b0;
        end else if (w_free_node) begin
            r_cur         <= w_next_ptr;
            // Wraps modulo 2^ADDR_W; a legal list never reaches the wrap.
            r_freed_count <= r_freed_count + ADDR_W'(1);
        end else if ((r_state == FCL_WR) && !w_used) begin
            r_error       <= 1'b1;
        end
    end

    assign error       = r_error;
    assign freed_count = r_freed_count;
    assign dbg_state   = r_state;

endmodule
